// File: rtl/dispense_timer_if.sv
// Handshake bundle between the brew sequencer and the dispense timer.
interface dispense_timer_if #(
  parameter int SEC_W = 8
);
  logic             start_timer;
  logic [1:0]       length_time;
  logic [2:0]       ing_type;
  logic             abort;
  logic             t_expired;
  logic             busy;
  logic [6:0]       valves;
  logic [SEC_W-1:0] secs_left;

  modport master (
    output start_timer, length_time, ing_type, abort,
    input  t_expired, busy, valves, secs_left
  );

  modport slave (
    input  start_timer, length_time, ing_type, abort,
    output t_expired, busy, valves, secs_left
  );
endinterface

// File: rtl/dispense_timer.sv
// Timed valve driver: opens one ingredient valve for a programmed
// number of seconds, then pulses t_expired for the sequencer.
module dispense_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int T_LEN0   = 3,
  parameter int T_LEN1   = 6,
  parameter int T_LEN2   = 10,
  parameter int T_LEN3   = 15,
  parameter int SEC_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  dispense_timer_if.slave bus
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [2:0]       ing_q, ing_d;
  logic             exp_q, exp_d;
  logic             busy_q, busy_d;
  logic [6:0]       valves_q, valves_d;
  logic [SEC_W-1:0] len_sel;
  logic             tick;

  function automatic logic [6:0] onehot(
    input logic [2:0] ing
  );
    logic [6:0] v;
    v = '0;
    if (ing != 3'd0) v[ing - 3'd1] = 1'b1;
    return v;
  endfunction

  always_comb begin
    len_sel = SEC_W'(T_LEN0);
    unique case (bus.length_time)
      2'd0: len_sel = SEC_W'(T_LEN0);
      2'd1: len_sel = SEC_W'(T_LEN1);
      2'd2: len_sel = SEC_W'(T_LEN2);
      2'd3: len_sel = SEC_W'(T_LEN3);
    endcase
  end

  assign tick = (pre_q == PMAX);

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    secs_d   = secs_q;
    ing_d    = ing_q;
    exp_d    = 1'b0;
    busy_d   = 1'b0;
    valves_d = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_timer && !bus.abort) begin
          state_d  = RUN;
          ing_d    = bus.ing_type;
          secs_d   = len_sel;
          pre_d    = '0;
          busy_d   = 1'b1;
          valves_d = onehot(bus.ing_type);
        end
      end
      RUN: begin
        // abort wins over a completing tick
        if (bus.abort) begin
          state_d = IDLE;
          secs_d  = '0;
          pre_d   = '0;
        end else begin
          pre_d    = tick ? '0 : pre_q + PW'(1);
          busy_d   = 1'b1;
          valves_d = onehot(ing_q);
          if (tick) begin
            if (secs_q > SEC_W'(1)) begin
              secs_d = secs_q - SEC_W'(1);
            end else begin
              secs_d   = '0;
              state_d  = DONE;
              exp_d    = 1'b1;
              busy_d   = 1'b0;
              valves_d = '0;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        secs_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      secs_q   <= '0;
      ing_q    <= '0;
      exp_q    <= 1'b0;
      busy_q   <= 1'b0;
      valves_q <= '0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      secs_q   <= secs_d;
      ing_q    <= ing_d;
      exp_q    <= exp_d;
      busy_q   <= busy_d;
      valves_q <= valves_d;
    end
  end

  assign bus.t_expired = exp_q;
  assign bus.busy      = busy_q;
  assign bus.valves    = valves_q;
  assign bus.secs_left = secs_q;

endmodule

// File: tb/tb_dispense_timer.sv
// Cycle-accurate scoreboard bench for dispense_timer at TICK_DIV=4.
module tb_dispense_timer;

  localparam int TD = 4;

  logic clk;
  logic rst;

  dispense_timer_if #(.SEC_W(8)) bus ();

  dispense_timer #(
    .TICK_DIV(TD),
    .T_LEN0  (3),
    .T_LEN1  (6),
    .T_LEN2  (10),
    .T_LEN3  (15),
    .SEC_W   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       t;
    logic       busy;
    logic [6:0] valves;
    int         secs;
  } obs_t;

  typedef struct {
    logic [1:0] len;
    logic [2:0] ing;
    logic       ab_idle;
    int         abort_at;
    int         restart_at;
  } vec_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  string tag;

  function automatic int secs_of(input logic [1:0] l);
    case (l)
      2'd0: return 3;
      2'd1: return 6;
      2'd2: return 10;
      default: return 15;
    endcase
  endfunction

  function automatic logic [6:0] oh(input logic [2:0] i);
    logic [6:0] one;
    one = 7'd1;
    return (i == 3'd0) ? 7'd0 : (one << (i - 3'd1));
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic push(input logic t, input logic b,
                      input logic [6:0] v, input int s);
    obs_t o;
    o.t = t; o.busy = b; o.valves = v; o.secs = s;
    sb.push_back(o);
  endtask

  task automatic step();
    obs_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s sb_empty: got 0 expected 1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " t_expired"}, int'(bus.t_expired), int'(e.t));
    chk({tag, " busy"}, int'(bus.busy), int'(e.busy));
    chk({tag, " valves"}, int'(bus.valves), int'(e.valves));
    chk({tag, " secs_left"}, int'(bus.secs_left), e.secs);
  endtask

  task automatic run_row(input vec_t v);
    int n, total;
    n = secs_of(v.len);
    total = n * TD;
    bus.start_timer = 1'b1;
    bus.length_time = v.len;
    bus.ing_type    = v.ing;
    bus.abort       = v.ab_idle;
    if (v.ab_idle) begin
      push(0, 0, 7'd0, 0);
      step();
      bus.start_timer = 1'b0;
      bus.abort       = 1'b0;
      push(0, 0, 7'd0, 0);
      step();
      return;
    end
    push(0, 1, oh(v.ing), n);
    step();
    for (int i = 0; i < total; i++) begin
      bus.start_timer = (i == v.restart_at);
      bus.length_time = ~v.len;
      bus.ing_type    = v.ing + 3'd1;
      bus.abort       = (i == v.abort_at);
      if (i == v.abort_at) begin
        push(0, 0, 7'd0, 0);
        step();
        bus.abort = 1'b0;
        push(0, 0, 7'd0, 0);
        step();
        return;
      end
      if (i == total - 1)
        push(1, 0, 7'd0, 0);
      else
        push(0, 1, oh(v.ing), n - (i + 1) / TD);
      step();
    end
    bus.start_timer = 1'b0;
    bus.abort       = 1'b0;
    push(0, 0, 7'd0, 0);
    step();
  endtask

  vec_t rows[8];

  initial begin
    rows[0] = '{2'd0, 3'd3, 1'b0, -1, -1};
    rows[1] = '{2'd3, 3'd0, 1'b0, -1, -1};
    rows[2] = '{2'd1, 3'd5, 1'b0, 10, -1};
    rows[3] = '{2'd1, 3'd1, 1'b0, -1, 5};
    rows[4] = '{2'd2, 3'd7, 1'b0, -1, -1};
    rows[5] = '{2'd0, 3'd2, 1'b1, -1, -1};
    rows[6] = '{2'd0, 3'd4, 1'b0, 11, -1};
    rows[7] = '{2'd2, 3'd6, 1'b0, 0, -1};

    bus.start_timer = 1'b0;
    bus.length_time = 2'd0;
    bus.ing_type    = 3'd0;
    bus.abort       = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tag = "reset";
    chk("reset t_expired", int'(bus.t_expired), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset valves", int'(bus.valves), 0);
    chk("reset secs_left", int'(bus.secs_left), 0);
    @(negedge clk);
    rst = 1'b0;
    push(0, 0, 7'd0, 0);
    step();

    foreach (rows[r]) begin
      tag = $sformatf("row%0d", r);
      run_row(rows[r]);
    end

    // continuous start: two back-to-back dispenses
    tag = "hold";
    bus.start_timer = 1'b1;
    bus.length_time = 2'd0;
    bus.ing_type    = 3'd2;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 3 * TD; i++) begin
        push(0, 1, 7'b0000010, 3 - i / TD);
        step();
      end
      push(1, 0, 7'd0, 0);
      step();
      push(0, 0, 7'd0, 0);
      step();
    end
    bus.start_timer = 1'b0;
    push(0, 0, 7'd0, 0);
    step();

    // asynchronous reset in the middle of a run
    tag = "arst";
    bus.start_timer = 1'b1;
    bus.length_time = 2'd1;
    bus.ing_type    = 3'd5;
    push(0, 1, 7'b0010000, 6);
    step();
    bus.start_timer = 1'b0;
    for (int i = 1; i < 6; i++) begin
      push(0, 1, 7'b0010000, 6 - i / TD);
      step();
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst t_expired", int'(bus.t_expired), 0);
    chk("arst busy", int'(bus.busy), 0);
    chk("arst valves", int'(bus.valves), 0);
    chk("arst secs_left", int'(bus.secs_left), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      push(0, 0, 7'd0, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispense_timer.md
Name: dispense_timer

Overview:
- Timed actuator stage driven by the brew-sequencing FSM.
- Accepts a start_timer pulse with a length_time code and an ing_type. Opens the matching ingredient valve for the programmed number of seconds, then returns a one-cycle t_expired pulse so the sequencer can advance to its next ingredient.
- Also supplies busy and a seconds-remaining count for the display.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick; legal range ≥1.
- T_LEN0, 3: seconds for length_time=0; must be ≥1.
- T_LEN1, 6: seconds for length_time=1; must be ≥1.
- T_LEN2, 10: seconds for length_time=2; must be ≥1.
- T_LEN3, 15: seconds for length_time=3; must be ≥1.
- SEC_W, 8: width of the seconds counter; every T_LENx must be < 2^SEC_W.

Ports:
- clk, input, 1: system clock. Everything is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start_timer, input, 1: request to start a dispense. Sampled only in IDLE.
- length_time, input, 2: duration code, sampled with start_timer.
- ing_type, input, 3: ingredient code, sampled with start_timer. 0 means timed wait with no valve.
- abort, input, 1: cancels the current dispense.
- t_expired, output, 1: registered one-cycle pulse on normal completion.
- busy, output, 1: high while in RUN.
- valves, output, 7: one-hot valve drive. Bit (ing_type-1) is high during RUN.
- secs_left, output, SEC_W: remaining whole seconds. 0 when not running.

Behaviour:
- Reset and clock: rst and clk as fixed above. On rst: state=IDLE, prescaler=0, secs_left=0, latched ing=0, t_expired=0, busy=0, valves=0. Asserting rst mid-RUN kills the valves immediately and no t_expired is produced.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If start_timer=1 and abort=0 at edge k: go to RUN at k+1.
  - At the same edge, latch ing_type, load secs_left from the T_LENx entry selected by length_time, and clear the prescaler.
  - busy and valves are asserted from cycle k+1.
  - If start_timer and abort are both 1: stay in IDLE.
- RUN:
  - busy=1.
  - valves = one-hot of latched ing (bit ing-1). If latched ing=0, valves stay 0.
  - Prescaler counts 0..TICK_DIV-1, wrapping to 0. A wrap is a tick.
  - On a tick with secs_left>1: decrement secs_left.
  - On a tick with secs_left==1: secs_left becomes 0 and the state goes to DONE.
  - Total RUN residence is exactly N*TICK_DIV cycles, where N is the loaded seconds.
  - start_timer is ignored in RUN: no restart, no re-latch.
  - Changes on length_time or ing_type are ignored in RUN.
  - abort=1: next state IDLE. valves, busy and secs_left clear, no t_expired. abort has priority over a completing tick in the same cycle.
- DONE:
  - Lasts exactly one cycle: t_expired=1, busy=0, valves=0, secs_left=0. Then IDLE unconditionally.
  - start_timer and abort are ignored in DONE, so the earliest restart is sampled in the IDLE cycle after DONE.
- Prescaler width: clog2(TICK_DIV), minimum 1 bit. With TICK_DIV=1 every RUN cycle is a tick.
- Back-to-back operation: a start held high continuously gives one dispense, one DONE cycle, then a new dispense starting from the following IDLE sample.
  - The minimum gap between two dispenses is therefore DONE + IDLE = 2 cycles with valves off.
- No combinational path from any input to any output.

Test Plan (TICK_DIV=4, defaults otherwise):
- Reset, then start_timer pulse with length_time=0, ing_type=3:
  - valves=7'b0000100 and busy=1 from the next cycle for exactly 12 cycles.
  - secs_left reads 3,2,1 for 4 cycles each.
  - Then t_expired=1 for 1 cycle with valves=0, then IDLE.
- Start with length_time=3, ing_type=0: busy for 60 cycles, valves stay 0, single t_expired pulse.
- Start with length_time=1, ing_type=5; assert abort at cycle 10 of RUN: valves and busy are 0 next cycle, t_expired never pulses.
- Start, then pulse start_timer again at RUN cycle 5 with different length_time and ing_type: no effect, still 24 cycles total with the original valve.
- Start and abort asserted together in IDLE: stays IDLE, busy=0.
- Assert rst asynchronously mid-RUN (between edges): valves, busy and secs_left go to 0 without waiting for clk; no t_expired after release.
- Hold start_timer high continuously with length_time=0: repeated 12-cycle RUN windows, each followed by one t_expired cycle and one IDLE cycle.
